rt_clock_param: RTL

//  Parametrised real-time clock: prescales the system clock to 1 Hz and keeps time as hh:mm:ss.

---
 rtl/rt_clock_param.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/rt_clock_param.sv
`default_nettype none
// ============================================================================
// Module   : rt_clock_param
// Brief    : Real-time clock (hh:mm:ss) with prescaler, set handshake,
//            12/24 h display, optional BCD output, day counter and alarm.
// Revision : 1.0  initial release
// ============================================================================
module rt_clock_param #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned BCD_OUT = 0,
    parameter int unsigned DAY_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             mode12,
    input  logic             set_valid,
    output logic             set_ready,
    input  logic [23:0]      set_data,
    output logic             set_err,
    input  logic             alarm_en,
    input  logic [23:0]      alarm_time,
    output logic             alarm_hit,
    output logic [23:0]      time_out,
    output logic             pm,
    output logic             sec_pulse,
    output logic             day_pulse,
    output logic [DAY_W-1:0] day_cnt
);

    localparam int unsigned c_presc_w = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_APPLY = 2'd1,
        S_ERR   = 2'd2
    } state_t;

    state_t                 state_q,     state_d;
    logic [c_presc_w-1:0]   presc_q,     presc_d;
    logic [4:0]             hour_q,      hour_d;
    logic [5:0]             min_q,       min_d;
    logic [5:0]             sec_q,       sec_d;
    logic [4:0]             set_hour_q,  set_hour_d;
    logic [5:0]             set_min_q,   set_min_d;
    logic [5:0]             set_sec_q,   set_sec_d;
    logic [DAY_W-1:0]       day_cnt_q,   day_cnt_d;
    logic                   sec_pulse_q, sec_pulse_d;
    logic                   day_pulse_q, day_pulse_d;
    logic                   alarm_hit_q, alarm_hit_d;
    logic [23:0]            time_out_q,  time_out_d;
    logic                   pm_q,        pm_d;

    logic                   w_tick;
    logic                   w_tick_eff;
    logic                   w_set_ok;
    logic                   w_sec_wrap;
    logic                   w_min_wrap;
    logic                   w_hour_wrap;
    logic                   w_day_carry;
    logic [4:0]             w_adv_hour;
    logic [5:0]             w_adv_min;
    logic [5:0]             w_adv_sec;
    logic [4:0]             w_disp_hour;
    logic [23:0]            w_time_fmt;

    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        return ((v / 8'd10) << 4) | (v % 8'd10);
    endfunction

    assign w_tick     = run && (presc_q == c_presc_max);
    // A load in S_APPLY overrides any tick landing in the same cycle.
    assign w_tick_eff = w_tick && (state_q != S_APPLY);

    assign w_set_ok = (set_data[23:16] <= 8'd23) &&
                      (set_data[15:8]  <= 8'd59) &&
                      (set_data[7:0]   <= 8'd59);

    // Full seconds -> minutes -> hours ripple resolved in one cycle.
    assign w_sec_wrap  = (sec_q  == 6'd59);
    assign w_min_wrap  = (min_q  == 6'd59);
    assign w_hour_wrap = (hour_q == 5'd23);
    assign w_day_carry = w_sec_wrap && w_min_wrap && w_hour_wrap;
    assign w_adv_sec   = w_sec_wrap ? 6'd0 : sec_q + 6'd1;
    assign w_adv_min   = !w_sec_wrap ? min_q :
                         (w_min_wrap ? 6'd0 : min_q + 6'd1);
    assign w_adv_hour  = !(w_sec_wrap && w_min_wrap) ? hour_q :
                         (w_hour_wrap ? 5'd0 : hour_q + 5'd1);

    always_comb begin
        state_d    = state_q;
        set_hour_d = set_hour_q;
        set_min_d  = set_min_q;
        set_sec_d  = set_sec_q;
        case (state_q)
            S_IDLE: begin
                if (set_valid) begin
                    set_hour_d = set_data[20:16];
                    set_min_d  = set_data[13:8];
                    set_sec_d  = set_data[5:0];
                    state_d    = w_set_ok ? S_APPLY : S_ERR;
                end
            end
            S_APPLY: state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        presc_d     = presc_q;
        hour_d      = hour_q;
        min_d       = min_q;
        sec_d       = sec_q;
        day_cnt_d   = day_cnt_q;
        sec_pulse_d = 1'b0;
        day_pulse_d = 1'b0;
        alarm_hit_d = 1'b0;
        if (state_q == S_APPLY) begin
            presc_d = '0;
            hour_d  = set_hour_q;
            min_d   = set_min_q;
            sec_d   = set_sec_q;
        end else begin
            if (run) begin
                presc_d = w_tick ? '0 : presc_q + c_presc_w'(1);
            end
            if (w_tick_eff) begin
                hour_d      = w_adv_hour;
                min_d       = w_adv_min;
                sec_d       = w_adv_sec;
                sec_pulse_d = 1'b1;
                alarm_hit_d = alarm_en &&
                              ({3'b000, w_adv_hour, 2'b00, w_adv_min,
                                2'b00, w_adv_sec} == alarm_time);
                if (w_day_carry) begin
                    day_cnt_d   = day_cnt_q + DAY_W'(1);
                    day_pulse_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_disp_hour = hour_q;
        if (mode12) begin
            if (hour_q == 5'd0) begin
                w_disp_hour = 5'd12;
            end else if (hour_q > 5'd12) begin
                w_disp_hour = hour_q - 5'd12;
            end
        end
    end

    generate
        if (BCD_OUT != 0) begin : g_bcd
            assign w_time_fmt = {to_bcd({3'b000, w_disp_hour}),
                                 to_bcd({2'b00, min_q}),
                                 to_bcd({2'b00, sec_q})};
        end else begin : g_bin
            assign w_time_fmt = {3'b000, w_disp_hour, 2'b00, min_q, 2'b00, sec_q};
        end
    endgenerate

    always_comb begin
        time_out_d = w_time_fmt;
        pm_d       = (hour_q >= 5'd12);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            hour_q      <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            set_hour_q  <= '0;
            set_min_q   <= '0;
            set_sec_q   <= '0;
            day_cnt_q   <= '0;
            sec_pulse_q <= 1'b0;
            day_pulse_q <= 1'b0;
            alarm_hit_q <= 1'b0;
            time_out_q  <= '0;
            pm_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            set_hour_q  <= set_hour_d;
            set_min_q   <= set_min_d;
            set_sec_q   <= set_sec_d;
            day_cnt_q   <= day_cnt_d;
            sec_pulse_q <= sec_pulse_d;
            day_pulse_q <= day_pulse_d;
            alarm_hit_q <= alarm_hit_d;
            time_out_q  <= time_out_d;
            pm_q        <= pm_d;
        end
    end

    assign set_ready = (state_q == S_IDLE);
    assign set_err   = (state_q == S_ERR);
    assign alarm_hit = alarm_hit_q;
    assign sec_pulse = sec_pulse_q;
    assign day_pulse = day_pulse_q;
    assign day_cnt   = day_cnt_q;
    assign time_out  = time_out_q;
    assign pm        = pm_q;

endmodule
`default_nettype wire
